store_commit_buffer: RTL and testbench

//  Receives committed stores from the ROB commit port and drains them in order to data memory.
//  It holds them in a circular FIFO and issues one request per store over a req/ack handshake.

---
 rtl/store_commit_buffer.sv | 248 ++++++++++++++++++++++++
 tb/tb_store_commit_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// -----------------------------------------------------------------------------
// store_commit_buffer
//
// Holds stores that the ROB has committed and drains them in program order to
// data memory over a req/ack handshake, one request per store. Each store is
// converted to its memory form (word address, lane-replicated data, byte
// enables) when it is pushed, so the drain side forwards the head entry as-is.
// Because committed stores are architectural, ROB flushes and exceptions do not
// affect the buffer. Load addresses are compared against every pending word so
// that the load unit can stall loads that alias a pending store.
//
// Ports
//   clk, rst                   rising-edge clock, async active-low reset
//   commit_MemWrite            one-cycle pulse per committed store
//   commit_Addr/value/funct3   store byte address, raw data, size (SB/SH/SW)
//   ld_addr, ld_valid          load probe for the alias check
//   mem_ack                    memory accepted the current request
//   mem_req                    request valid (high while BUSY)
//   mem_addr/wdata/be          head store, word-aligned, lane-shifted
//   buf_full/empty/count       occupancy
//   ld_conflict                comb.: load word matches some pending store
//   store_err                  one-cycle pulse after a rejected store
//   overflow_err               sticky: store dropped because buffer was full
// -----------------------------------------------------------------------------
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_MemWrite,
  input  logic [31:0]      commit_Addr,
  input  logic [31:0]      commit_value,
  input  logic [2:0]       commit_funct3,
  input  logic [31:0]      ld_addr,
  input  logic             ld_valid,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             buf_full,
  output logic             buf_empty,
  output logic [CNT_W-1:0] buf_count,
  output logic             ld_conflict,
  output logic             store_err,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  // A buffered store in the exact form it is presented to memory.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Storage and control state
  // ---------------------------------------------------------------------------
  entry_t             entries_q [DEPTH];
  logic [DEPTH-1:0]   valid_q,   valid_d;
  logic [PTR_W-1:0]   head_q,    head_d;
  logic [PTR_W-1:0]   tail_q,    tail_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  state_e             state_q,   state_d;
  logic               store_err_q, store_err_d;
  logic               overflow_q,  overflow_d;

  // ---------------------------------------------------------------------------
  // Store encoding
  // ---------------------------------------------------------------------------
  logic [1:0]  lane;
  logic        enc_ok;
  logic [3:0]  enc_be;
  logic [31:0] enc_data;
  entry_t      push_entry;

  assign lane = commit_Addr[1:0];

  // NOTE: every combinational output gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    enc_ok   = 1'b0;
    enc_be   = 4'h0;
    enc_data = 32'h0;
    case (commit_funct3)
      F3_SB: begin
        enc_ok   = 1'b1;
        enc_be   = 4'b0001 << lane;
        enc_data = {4{commit_value[7:0]}};
      end
      F3_SH: begin
        enc_ok   = ~lane[0];
        enc_be   = 4'b0011 << lane;
        enc_data = {2{commit_value[15:0]}};
      end
      F3_SW: begin
        enc_ok   = (lane == 2'b00);
        enc_be   = 4'hF;
        enc_data = commit_value;
      end
      default: ;
    endcase
  end

  assign push_entry = '{waddr: commit_Addr[31:2], data: enc_data, be: enc_be};

  // ---------------------------------------------------------------------------
  // Push / pop decisions
  // ---------------------------------------------------------------------------
  logic legal_store;
  logic pop;
  logic push;
  logic full_now;

  assign full_now    = (count_q == FULL_CNT);
  assign legal_store = commit_MemWrite & enc_ok;
  assign pop         = mem_req & mem_ack;
  // A slot freed by this cycle's pop may be reused by this cycle's push,
  // which is what lets a store commit into a full buffer on an ack cycle.
  assign push        = legal_store & (~full_now | pop);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    count_d     = count_q;
    store_err_d = commit_MemWrite & ~enc_ok;
    overflow_d  = overflow_q | (legal_store & full_now & ~pop);

    // Clear before set: at full with push+pop, head and tail index the same
    // slot and it must stay valid for the newly written store.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  // IDLE looks at the registered count, so a store pushed into an empty
  // buffer reaches memory two cycles after its commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_BUSY;
      S_BUSY: if (pop && count_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      state_q     <= S_IDLE;
      store_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      store_err_q <= store_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the payload array has no reset; valid_q gates every read, so stale
  // contents are never observed and the array can map to plain storage.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Load alias check (includes the head store still in flight)
  // ---------------------------------------------------------------------------
  logic alias_hit;
  logic [1:0] ld_lane_unused;

  assign ld_lane_unused = ld_addr[1:0];

  always_comb begin
    alias_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && entries_q[i].waddr == ld_addr[31:2]) begin
        alias_hit = 1'b1;
      end
    end
  end

  assign ld_conflict = ld_valid & alias_hit;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  entry_t head_entry;
  logic   busy;

  assign busy       = (state_q == S_BUSY);
  assign head_entry = entries_q[head_q];

  // Memory outputs read zero outside BUSY so the bus is quiet when idle.
  assign mem_req   = busy;
  assign mem_addr  = busy ? {head_entry.waddr, 2'b00} : 32'h0;
  assign mem_wdata = busy ? head_entry.data : 32'h0;
  assign mem_be    = busy ? head_entry.be : 4'h0;

  assign buf_count    = count_q;
  assign buf_full     = full_now;
  assign buf_empty    = (count_q == '0);
  assign store_err    = store_err_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_commit_buffer
//
// Directed scenarios for latency, encoding, ordering, error reporting, full /
// overflow behaviour, load alias detection and mid-handshake reset, followed
// by a randomized run compared cycle by cycle against a queue-based model of
// the buffer.
// -----------------------------------------------------------------------------
module tb_store_commit_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             commit_MemWrite;
  logic [31:0]      commit_Addr;
  logic [31:0]      commit_value;
  logic [2:0]       commit_funct3;
  logic [31:0]      ld_addr;
  logic             ld_valid;
  logic             mem_ack;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic             ld_conflict;
  logic             store_err;
  logic             overflow_err;

  int n_total = 0;
  int n_pass  = 0;

  store_commit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .commit_MemWrite (commit_MemWrite),
    .commit_Addr     (commit_Addr),
    .commit_value    (commit_value),
    .commit_funct3   (commit_funct3),
    .ld_addr         (ld_addr),
    .ld_valid        (ld_valid),
    .mem_ack         (mem_ack),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .buf_full        (buf_full),
    .buf_empty       (buf_empty),
    .buf_count       (buf_count),
    .ld_conflict     (ld_conflict),
    .store_err       (store_err),
    .overflow_err    (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference form of a store as memory should see it.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    commit_MemWrite = 1'b0;
    commit_Addr     = 32'h0;
    commit_value    = 32'h0;
    commit_funct3   = 3'b000;
    ld_addr         = 32'h0;
    ld_valid        = 1'b0;
    mem_ack         = 1'b0;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    commit_MemWrite = 1'b1;
    commit_funct3   = f3;
    commit_Addr     = a;
    commit_value    = v;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Memory form of a store, from the size rules written arithmetically.
  function automatic void model_enc(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] v, output bit ok, output st_t e);
    int lane;
    lane   = int'(a % 4);
    ok     = 1'b0;
    e.addr = a - 32'(lane);
    e.data = 32'h0;
    e.be   = 4'h0;
    case (f3)
      3'd0: begin ok = 1'b1; e.be = 4'(1 << lane); e.data = 32'(v[7:0]) * 32'h0101_0101; end
      3'd1: begin ok = (lane % 2 == 0); e.be = 4'(3 << lane); e.data = 32'(v[15:0]) * 32'h0001_0001; end
      3'd2: begin ok = (lane == 0); e.be = 4'hF; e.data = v; end
      default: ;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #12;
    n_total++; if (mem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", mem_wdata); else n_pass++;
    n_total++; if (mem_be !== 4'h0) $display("FAIL reset_be got %h exp 0", mem_be); else n_pass++;
    n_total++; if (buf_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", buf_count); else n_pass++;
    n_total++; if (buf_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", buf_empty); else n_pass++;
    n_total++; if (buf_full !== 1'b0) $display("FAIL reset_full got %b exp 0", buf_full); else n_pass++;
    n_total++; if (store_err !== 1'b0) $display("FAIL reset_serr got %b exp 0", store_err); else n_pass++;
    n_total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow_err); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // SW into an empty buffer, memory always ready.
  task automatic test_sw_latency();
    mem_ack = 1'b1;
    drive_store(3'b010, 32'h100, 32'hDEAD_BEEF);
    tick();                                       // cycle N+1
    commit_MemWrite = 1'b0;
    n_total++; if (mem_req !== 1'b0) $display("FAIL sw_req_n1 got %b exp 0", mem_req); else n_pass++;
    n_total++; if (buf_count !== 4'd1) $display("FAIL sw_count_n1 got %0d exp 1", buf_count); else n_pass++;
    tick();                                       // cycle N+2
    n_total++; if (mem_req !== 1'b1) $display("FAIL sw_req_n2 got %b exp 1", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'h100) $display("FAIL sw_addr got %h exp 00000100", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); else n_pass++;
    n_total++; if (mem_be !== 4'hF) $display("FAIL sw_be got %h exp f", mem_be); else n_pass++;
    tick();
    n_total++; if (mem_req !== 1'b0) $display("FAIL sw_req_after got %b exp 0", mem_req); else n_pass++;
    n_total++; if (buf_empty !== 1'b1) $display("FAIL sw_empty_after got %b exp 1", buf_empty); else n_pass++;
    mem_ack = 1'b0;
  endtask

  // SB at a high lane then SH at the upper half, drained in order.
  task automatic test_sub_word_order();
    drive_store(3'b000, 32'h103, 32'h1234_5678);
    tick();
    drive_store(3'b001, 32'h202, 32'h0000_ABCD);
    tick();
    commit_MemWrite = 1'b0;
    n_total++; if (mem_req !== 1'b1) $display("FAIL sb_req got %b exp 1", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'h100) $display("FAIL sb_addr got %h exp 00000100", mem_addr); else n_pass++;
    n_total++; if (mem_be !== 4'b1000) $display("FAIL sb_be got %b exp 1000", mem_be); else n_pass++;
    n_total++; if (mem_wdata !== 32'h7878_7878) $display("FAIL sb_wdata got %h exp 78787878", mem_wdata); else n_pass++;
    mem_ack = 1'b1;
    tick();
    n_total++; if (mem_req !== 1'b1) $display("FAIL sh_req got %b exp 1", mem_req); else n_pass++;
    n_total++; if (mem_addr !== 32'h200) $display("FAIL sh_addr got %h exp 00000200", mem_addr); else n_pass++;
    n_total++; if (mem_be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", mem_be); else n_pass++;
    n_total++; if (mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got %h exp abcdabcd", mem_wdata); else n_pass++;
    tick();
    n_total++; if (buf_empty !== 1'b1) $display("FAIL order_empty got %b exp 1", buf_empty); else n_pass++;
    mem_ack = 1'b0;
  endtask

  // Misaligned SH and an unsupported funct3 are both rejected.
  task automatic test_illegal();
    int req_seen;
    req_seen = 0;
    mem_ack  = 1'b1;
    drive_store(3'b001, 32'h101, 32'h1111);
    tick();
    n_total++; if (store_err !== 1'b1) $display("FAIL ill_serr1 got %b exp 1", store_err); else n_pass++;
    drive_store(3'b011, 32'h100, 32'h2222);
    tick();
    commit_MemWrite = 1'b0;
    n_total++; if (store_err !== 1'b1) $display("FAIL ill_serr2 got %b exp 1", store_err); else n_pass++;
    n_total++; if (buf_count !== 4'd0) $display("FAIL ill_count got %0d exp 0", buf_count); else n_pass++;
    tick();
    n_total++; if (store_err !== 1'b0) $display("FAIL ill_serr_clear got %b exp 0", store_err); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (mem_req === 1'b1) req_seen++;
      tick();
    end
    n_total++; if (req_seen !== 0) $display("FAIL ill_req_cycles got %0d exp 0", req_seen); else n_pass++;
    n_total++; if (buf_empty !== 1'b1) $display("FAIL ill_empty got %b exp 1", buf_empty); else n_pass++;
    mem_ack = 1'b0;
  endtask

  // Fill, overflow without ack, push-at-full with ack, then drain.
  task automatic test_full_overflow();
    logic [31:0] exp_a [8];
    logic [31:0] exp_d [8];
    mem_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_store(3'b010, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      tick();
    end
    commit_MemWrite = 1'b0;
    n_total++; if (buf_full !== 1'b1) $display("FAIL fill_full got %b exp 1", buf_full); else n_pass++;
    n_total++; if (buf_count !== 4'd8) $display("FAIL fill_count got %0d exp 8", buf_count); else n_pass++;
    n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) $display("FAIL fill_head got req %b addr %h exp 1 00001000", mem_req, mem_addr); else n_pass++;
    n_total++; if (overflow_err !== 1'b0) $display("FAIL fill_ovf_pre got %b exp 0", overflow_err); else n_pass++;
    drive_store(3'b010, 32'h2000, 32'h2222_2222);
    tick();
    commit_MemWrite = 1'b0;
    n_total++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow_err); else n_pass++;
    n_total++; if (buf_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", buf_count); else n_pass++;
    drive_store(3'b010, 32'h3000, 32'h3333_3333);
    mem_ack = 1'b1;
    tick();
    commit_MemWrite = 1'b0;
    n_total++; if (buf_count !== 4'd8) $display("FAIL pushpop_count got %0d exp 8", buf_count); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      exp_a[k] = 32'h1000 + 32'(4 * (k + 1));
      exp_d[k] = 32'hA000_0000 + 32'(k + 1);
    end
    exp_a[7] = 32'h3000;
    exp_d[7] = 32'h3333_3333;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== exp_a[k] || mem_wdata !== exp_d[k])
        $display("FAIL drain_%0d got req %b addr %h data %h exp 1 %h %h", k, mem_req, mem_addr, mem_wdata, exp_a[k], exp_d[k]);
      else n_pass++;
      tick();
    end
    n_total++; if (buf_empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", buf_empty); else n_pass++;
    n_total++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow_err); else n_pass++;
    apply_reset();
    n_total++; if (overflow_err !== 1'b0) $display("FAIL ovf_reset got %b exp 0", overflow_err); else n_pass++;
  endtask

  // Word-granular alias check, including the ack cycle.
  task automatic test_conflict();
    int waited;
    mem_ack = 1'b0;
    drive_store(3'b010, 32'h400, 32'h1);
    tick();
    commit_MemWrite = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h402;
    #1;
    n_total++; if (ld_conflict !== 1'b1) $display("FAIL cf_same_word got %b exp 1", ld_conflict); else n_pass++;
    ld_addr = 32'h404;
    #1;
    n_total++; if (ld_conflict !== 1'b0) $display("FAIL cf_next_word got %b exp 0", ld_conflict); else n_pass++;
    ld_addr  = 32'h400;
    ld_valid = 1'b0;
    #1;
    n_total++; if (ld_conflict !== 1'b0) $display("FAIL cf_no_valid got %b exp 0", ld_conflict); else n_pass++;
    waited = 0;
    while (mem_req !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_total++; if (mem_req !== 1'b1) $display("FAIL cf_req_timeout got %b exp 1", mem_req); else n_pass++;
    ld_valid = 1'b1;
    ld_addr  = 32'h402;
    mem_ack  = 1'b1;
    #1;
    n_total++; if (ld_conflict !== 1'b1) $display("FAIL cf_ack_cycle got %b exp 1", ld_conflict); else n_pass++;
    tick();
    mem_ack = 1'b0;
    #1;
    n_total++; if (ld_conflict !== 1'b0) $display("FAIL cf_after_ack got %b exp 0", ld_conflict); else n_pass++;
    drive_idle();
  endtask

  // Reset while a request is outstanding.
  task automatic test_reset_midflight();
    int waited;
    int req_seen;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(3'b010, 32'h500 + 32'(4 * i), 32'(i));
      tick();
    end
    commit_MemWrite = 1'b0;
    waited = 0;
    while (mem_req !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_total++; if (mem_req !== 1'b1) $display("FAIL rm_req_timeout got %b exp 1", mem_req); else n_pass++;
    #3;
    rst = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rm_req_async got %b exp 0", mem_req); else n_pass++;
    n_total++; if (buf_count !== 4'd0) $display("FAIL rm_count got %0d exp 0", buf_count); else n_pass++;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    mem_ack = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req === 1'b1) req_seen++;
    end
    n_total++; if (req_seen !== 0) $display("FAIL rm_no_requests got %0d exp 0", req_seen); else n_pass++;
    n_total++; if (buf_empty !== 1'b1) $display("FAIL rm_empty got %b exp 1", buf_empty); else n_pass++;
    mem_ack = 1'b0;
  endtask

  // Random commits, acks and load probes against a queue model.
  task automatic test_random();
    st_t  mq[$];
    st_t  e;
    bit   ok;
    bit   exp_req, exp_serr, exp_ovf, exp_cf;
    bit   pop, push;
    int   size_before;
    apply_reset();
    exp_req  = 1'b0;
    exp_serr = 1'b0;
    exp_ovf  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      commit_MemWrite = ($urandom_range(0, 99) < 55);
      commit_funct3   = 3'($urandom_range(0, 4));
      commit_Addr     = 32'h800 + 32'($urandom_range(0, 47));
      commit_value    = $urandom;
      mem_ack         = ($urandom_range(0, 99) < 40);
      ld_valid        = ($urandom_range(0, 99) < 60);
      ld_addr         = 32'h800 + 32'($urandom_range(0, 47));
      #1;
      exp_cf = 1'b0;
      foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) exp_cf = 1'b1;
      exp_cf = exp_cf & ld_valid;
      n_total++; if (buf_count !== 4'(mq.size())) $display("FAIL rnd_count c%0d got %0d exp %0d", cyc, buf_count, mq.size()); else n_pass++;
      n_total++; if (mem_req !== exp_req) $display("FAIL rnd_req c%0d got %b exp %b", cyc, mem_req, exp_req); else n_pass++;
      n_total++; if (ld_conflict !== exp_cf) $display("FAIL rnd_conflict c%0d got %b exp %b", cyc, ld_conflict, exp_cf); else n_pass++;
      n_total++; if (store_err !== exp_serr) $display("FAIL rnd_serr c%0d got %b exp %b", cyc, store_err, exp_serr); else n_pass++;
      n_total++; if (overflow_err !== exp_ovf) $display("FAIL rnd_ovf c%0d got %b exp %b", cyc, overflow_err, exp_ovf); else n_pass++;
      if (exp_req && mq.size() > 0) begin
        n_total++;
        if (mem_addr !== mq[0].addr || mem_wdata !== mq[0].data || mem_be !== mq[0].be)
          $display("FAIL rnd_head c%0d got %h %h %h exp %h %h %h", cyc, mem_addr, mem_wdata, mem_be, mq[0].addr, mq[0].data, mq[0].be);
        else n_pass++;
      end
      // Model the clock edge.
      model_enc(commit_funct3, commit_Addr, commit_value, ok, e);
      size_before = mq.size();
      pop  = exp_req && mem_ack;
      push = commit_MemWrite && ok && (size_before < DEPTH || pop);
      if (commit_MemWrite && ok && size_before == DEPTH && !pop) exp_ovf = 1'b1;
      exp_serr = commit_MemWrite && !ok;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
      exp_req = exp_req ? (mq.size() > 0) : (size_before > 0);
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    test_reset();
    test_sw_latency();
    test_sub_word_order();
    test_illegal();
    test_full_overflow();
    test_conflict();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
